convolution: RTL and testbench
==============================

# convolution

Consumes the three-row pixel columns produced by the kernel-row line buffer and applies a programmable 3x3 convolution to each RGB565 pixel, one column per valid cycle. It keeps the horizontal 3x3 window, edge handling, the multiply-accumulate pipeline and coordinate re-alignment. It emits one filtered pixel per input column with matching hcount/vcount/valid, ready for the framebuffer or downstream filters.

## Interface
- HRES, 1280, active pixels per row
- VRES, 720, active rows per frame
- clk_in  input  1  system clock; one clock domain
- rst_in  input  1  synchronous, active-high reset
- data_in  input  3x16  column of RGB565 pixels; [0] top row, [1] centre row, [2] bottom row
- hcount_in  input  $clog2(HRES)  column index of data_in
- vcount_in  input  $clog2(VRES)  centre-row index of data_in
- data_valid_in  input  1  data_in/hcount_in/vcount_in valid this cycle
- coeffs_in  input  9x8 signed  kernel, index r*3+c, r=row 0..2 (top..bottom), c=col 0..2 (left..right)
- shift_in  input  4  right-shift applied to each channel sum
- line_out  output  16  filtered RGB565 pixel
- hcount_out  output  $clog2(HRES)  column of line_out
- vcount_out  output  $clog2(VRES)  row of line_out
- data_valid_out  output  1  outputs valid this cycle

## Operation
- Window: three 3x16 column registers L, C, R. On each data_valid_in: L<=C, C<=R, R<=data_in. Idle cycles hold all state.
- Each valid input completes the window centred on column hcount_in-1. Tags are hcount_out=hcount_in-1 and vcount_out=vcount_in. When hcount_in==0, the tags wrap to hcount_out=HRES-1 and vcount_out=vcount_in-1, with vcount 0 wrapping to VRES-1. That output is the previous row's last pixel.
- Edge clamp:
  - When hcount_in==0, the right column fed to the MAC is replaced with C.
  - When hcount_in==1, the left column is replaced with C.
- Channel split: R5=[15:11], G6=[10:5], B5=[4:0], each zero-extended to unsigned. Each is multiplied by a signed 8-bit coeff, and the 9 products are summed into a signed 18-bit accumulator.
- Result per channel: arithmetic shift right by shift_in, then clamp to [0,31] for R/B and [0,63] for G. Repack as RGB565.
- Coefficient latch: coeffs_in/shift_in are copied into internal registers only on a valid input with hcount_in==0 and vcount_in==0. The kernel is therefore constant for a whole frame.
- No backpressure. Every valid input yields exactly one valid output.

## Timing
- Pipeline, fixed 4 cycles; valid sampled at edge t gives data_valid_out high after edge t+4:
  - S1: window shift plus edge mux registered.
  - S2: 27 products registered.
  - S3: per-channel sums registered.
  - S4: shift, clamp and pack into output registers.
- hcount/vcount/valid travel in a parallel pipe of equal depth, so tags are always aligned with line_out.
- Back-to-back valids give one output per cycle. Gaps in data_valid_in reproduce as gaps in data_valid_out 4 cycles later.
- Outputs are registered; data_valid_out is low whenever its pipe bit is low. line_out/counts hold their last value while invalid.
- Reset values:
  - Outputs: line_out=0, hcount_out=0, vcount_out=0, data_valid_out=0.
  - Internal: window registers 0, all pipe valid bits 0.
  - Latched kernel: identity (coeff[4]=1, others 0), shift 0.
- Reset mid-frame: in-flight pixels are discarded, with no valid output for 4 cycles after release. The identity kernel is used until the next (0,0) input.

## Configuration
- CONV_EDGE_CLAMP_EN defined: column replication at hcount_in==0/1 as above.
- CONV_EDGE_CLAMP_EN undefined: no edge mux; the raw window is used, so edge pixels mix neighbouring-row data. This saves the muxes, and latency stays 4.

## Test plan
- Identity kernel, shift 0, ramp frame with pixel=hcount, HRES=8, VRES=4: each output equals its input column, with hcount_out=hcount_in-1 and 4-cycle latency. Input (0,1) yields output tag (7,0).
- Gaussian {1,2,1,2,4,2,1,2,1}, shift 4, constant 0x8410 field: every output is 0x8410, including all edge columns.
- Box kernel all 1, shift 0, constant 0xFFFF: sums 279/567 clamp, giving 0xFFFF.
- Laplacian {0,-1,0,-1,4,-1,0,-1,0} on constant 0xFFFF: result 0, with negative and zero clamp paths exercised.
- Edge clamp: row with column 0=0xF800 and rest 0, box kernel, shift 3. Output at hcount 0 uses a replicated left column. Repeat with the macro undefined and check that the values differ.
- Change coeffs_in mid-frame: outputs keep the old kernel until after the next (0,0) input. Assert rst_in mid-row: data_valid_out is 0 for 4 cycles and the identity kernel is restored.

Source files
------------

// File: rtl/convolution_if.sv
// Pixel-column stream into, and filtered RGB565 stream out of, the 3x3 convolution.
// The slave modport is the filter side; master is the producer/consumer side.
interface convolution_if #(
  parameter int HRES = 1280,
  parameter int VRES = 720
);
  localparam int HW = $clog2(HRES);
  localparam int VW = $clog2(VRES);

  logic        [15:0] data_in [3];
  logic      [HW-1:0] hcount_in;
  logic      [VW-1:0] vcount_in;
  logic               data_valid_in;
  logic signed  [7:0] coeffs_in [9];
  logic         [3:0] shift_in;
  logic        [15:0] line_out;
  logic      [HW-1:0] hcount_out;
  logic      [VW-1:0] vcount_out;
  logic               data_valid_out;

  modport master (
    output data_in, hcount_in, vcount_in, data_valid_in, coeffs_in, shift_in,
    input  line_out, hcount_out, vcount_out, data_valid_out
  );

  modport slave (
    input  data_in, hcount_in, vcount_in, data_valid_in, coeffs_in, shift_in,
    output line_out, hcount_out, vcount_out, data_valid_out
  );
endinterface

// File: rtl/convolution.sv
// Programmable 3x3 RGB565 convolution over line-buffer columns, 4-cycle fixed latency.
// Define CONV_EDGE_CLAMP_EN to replicate the centre column at row edges (hcount_in 0/1).
module convolution #(
  parameter int HRES = 1280,
  parameter int VRES = 720
) (
  input  logic           clk_in,
  input  logic           rst_in,
  convolution_if.slave   bus
);
  localparam int HW = $clog2(HRES);
  localparam int VW = $clog2(VRES);

  logic        [15:0] win_l [3];
  logic        [15:0] win_c [3];
  logic        [15:0] win_r [3];
  logic        [15:0] mac_q [3][3];
  logic signed  [7:0] coeff_q [9];
  logic signed  [7:0] coeff1 [9];
  logic         [3:0] shift_q, shift1, shift2, shift3;
  logic signed [13:0] prod_q [3][9];
  logic signed [17:0] sum_c [3];
  logic signed [17:0] sum_q [3];
  logic signed [17:0] shifted [3];
  logic         [4:0] pix_r, pix_b;
  logic         [5:0] pix_g;
  logic         [3:0] vld;
  logic      [HW-1:0] h_pipe [4];
  logic      [VW-1:0] v_pipe [4];
  logic      [HW-1:0] h_tag;
  logic      [VW-1:0] v_tag;
`ifdef CONV_EDGE_CLAMP_EN
  logic               clamp_l0, clamp_r0;
`endif

  function automatic logic signed [13:0] mul(input logic signed [7:0] k, input logic [5:0] px);
    return 14'(k) * $signed({8'd0, px});
  endfunction

  function automatic logic [5:0] sat(input logic signed [17:0] x, input logic signed [17:0] lim);
    if (x < 18'sd0) return 6'd0;
    if (x > lim) return lim[5:0];
    return x[5:0];
  endfunction

  // Column hcount_in==0 completes the previous row's last pixel.
  always_comb begin
    h_tag = bus.hcount_in - HW'(1);
    v_tag = bus.vcount_in;
    if (bus.hcount_in == '0) begin
      h_tag = HW'(HRES - 1);
      v_tag = (bus.vcount_in == '0) ? VW'(VRES - 1) : bus.vcount_in - VW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld     <= '0;
      shift_q <= '0;
      for (int i = 0; i < 3; i++) begin
        win_l[i] <= '0;
        win_c[i] <= '0;
        win_r[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        h_pipe[i] <= '0;
        v_pipe[i] <= '0;
      end
      for (int i = 0; i < 9; i++) coeff_q[i] <= (i == 4) ? 8'sd1 : 8'sd0;
`ifdef CONV_EDGE_CLAMP_EN
      clamp_l0 <= 1'b0;
      clamp_r0 <= 1'b0;
`endif
    end else begin
      vld <= {vld[2:0], bus.data_valid_in};
      if (bus.data_valid_in) begin
        win_l     <= win_c;
        win_c     <= win_r;
        win_r     <= bus.data_in;
        h_pipe[0] <= h_tag;
        v_pipe[0] <= v_tag;
`ifdef CONV_EDGE_CLAMP_EN
        clamp_r0  <= (bus.hcount_in == '0);
        clamp_l0  <= (bus.hcount_in == HW'(1));
`endif
        if (bus.hcount_in == '0 && bus.vcount_in == '0) begin
          coeff_q <= bus.coeffs_in;
          shift_q <= bus.shift_in;
        end
      end
      for (int s = 1; s < 4; s++) begin
        if (vld[s-1]) begin
          h_pipe[s] <= h_pipe[s-1];
          v_pipe[s] <= v_pipe[s-1];
        end
      end
    end
  end

  // Kernel and shift ride with the pixel so a frame-start latch never splits a pixel.
  always_ff @(posedge clk_in) begin
    if (vld[0]) begin
      mac_q[0] <= win_l;
      mac_q[1] <= win_c;
      mac_q[2] <= win_r;
`ifdef CONV_EDGE_CLAMP_EN
      if (clamp_l0) mac_q[0] <= win_c;
      if (clamp_r0) mac_q[2] <= win_c;
`endif
      coeff1 <= coeff_q;
      shift1 <= shift_q;
    end
    if (vld[1]) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          prod_q[0][r*3+c] <= mul(coeff1[r*3+c], {1'b0, mac_q[c][r][15:11]});
          prod_q[1][r*3+c] <= mul(coeff1[r*3+c], mac_q[c][r][10:5]);
          prod_q[2][r*3+c] <= mul(coeff1[r*3+c], {1'b0, mac_q[c][r][4:0]});
        end
      end
      shift2 <= shift1;
    end
    if (vld[2]) begin
      sum_q  <= sum_c;
      shift3 <= shift2;
    end
  end

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      sum_c[ch] = '0;
      for (int i = 0; i < 9; i++) sum_c[ch] = sum_c[ch] + 18'(prod_q[ch][i]);
    end
  end

  always_comb begin
    for (int ch = 0; ch < 3; ch++) shifted[ch] = sum_q[ch] >>> shift3;
    pix_r = 5'(sat(shifted[0], 18'sd31));
    pix_g = sat(shifted[1], 18'sd63);
    pix_b = 5'(sat(shifted[2], 18'sd31));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bus.line_out       <= '0;
      bus.hcount_out     <= '0;
      bus.vcount_out     <= '0;
      bus.data_valid_out <= 1'b0;
    end else begin
      bus.data_valid_out <= vld[3];
      if (vld[3]) begin
        bus.line_out   <= {pix_r, pix_g, pix_b};
        bus.hcount_out <= h_pipe[3];
        bus.vcount_out <= v_pipe[3];
      end
    end
  end
endmodule

// File: tb/tb_convolution.sv
`timescale 1ns/1ps
// Randomized frames checked against a per-pixel arithmetic model of the 3x3 filter,
// including output tags and the exact output cycle of every pixel.
module tb_convolution;
  localparam int HRES = 8;
  localparam int VRES = 4;

  typedef struct packed {
    logic [15:0] pix;
    logic  [2:0] h;
    logic  [1:0] v;
    logic [31:0] cyc;
  } out_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] cyc = '0;

  convolution_if #(.HRES(HRES), .VRES(VRES)) bus ();
  convolution #(.HRES(HRES), .VRES(VRES)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  out_t got_q[$];
  out_t exp_q[$];
  out_t cap;

  always @(negedge clk_in) begin
    if (bus.data_valid_out === 1'b1) begin
      cap = '{bus.line_out, bus.hcount_out, bus.vcount_out, cyc};
      got_q.push_back(cap);
    end
  end

  int passed = 0;
  int total  = 0;
  logic signed [7:0] k_drive [9];
  logic signed [7:0] k_alt [9];
  logic        [3:0] s_drive, s_alt;
  int                m_k [9];
  int                m_shift;
  logic       [15:0] hist [3][3];
  logic       [31:0] last_cyc;
  out_t              e, g;

  function automatic void model_reset();
    for (int a = 0; a < 3; a++) for (int r = 0; r < 3; r++) hist[a][r] = '0;
    for (int i = 0; i < 9; i++) m_k[i] = (i == 4) ? 1 : 0;
    m_shift = 0;
  endfunction

  function automatic logic [15:0] ref_pixel(input logic [15:0] col [3][3]);
    int acc [3];
    int res [3];
    int lim [3];
    logic [15:0] p;
    lim = '{31, 63, 31};
    acc = '{0, 0, 0};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p = col[c][r];
        acc[0] += m_k[r*3+c] * int'(p[15:11]);
        acc[1] += m_k[r*3+c] * int'(p[10:5]);
        acc[2] += m_k[r*3+c] * int'(p[4:0]);
      end
    end
    for (int ch = 0; ch < 3; ch++) begin
      res[ch] = acc[ch] >>> m_shift;
      if (res[ch] < 0) res[ch] = 0;
      if (res[ch] > lim[ch]) res[ch] = lim[ch];
    end
    return {res[0][4:0], res[1][5:0], res[2][4:0]};
  endfunction

  function automatic void model_step(input int h, input int v, input logic [15:0] d0, d1, d2);
    logic [15:0] col [3][3];
    out_t o;
    hist[0] = hist[1];
    hist[1] = hist[2];
    hist[2] = '{d0, d1, d2};
    if (h == 0 && v == 0) begin
      for (int i = 0; i < 9; i++) m_k[i] = int'(k_drive[i]);
      m_shift = int'(s_drive);
    end
    col = hist;
`ifdef CONV_EDGE_CLAMP_EN
    if (h == 0) col[2] = hist[1];
    if (h == 1) col[0] = hist[1];
`endif
    o.pix = ref_pixel(col);
    o.h   = 3'((h == 0) ? HRES - 1 : h - 1);
    o.v   = 2'((h != 0) ? v : (v == 0) ? VRES - 1 : v - 1);
    o.cyc = cyc + 5;
    exp_q.push_back(o);
  endfunction

  task automatic drive_px(input int h, input int v, input logic [15:0] d0, d1, d2);
    @(posedge clk_in); #1;
    rst_in            = 1'b0;
    bus.data_in[0]    = d0;
    bus.data_in[1]    = d1;
    bus.data_in[2]    = d2;
    bus.hcount_in     = 3'(h);
    bus.vcount_in     = 2'(v);
    bus.coeffs_in     = k_drive;
    bus.shift_in      = s_drive;
    bus.data_valid_in = 1'b1;
    last_cyc          = cyc;
    model_step(h, v, d0, d1, d2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      bus.data_valid_in = 1'b0;
    end
  endtask

  // mode 0: ramp (pixel = hcount), 1: constant, 2: column 0 red else black, 3: random
  task automatic drive_frame(input int mode, input logic [15:0] val, input int gap_pct,
                             input int chg_idx);
    logic [15:0] d [3];
    for (int v = 0; v < VRES; v++) begin
      for (int h = 0; h < HRES; h++) begin
        if (v * HRES + h == chg_idx) begin
          k_drive = k_alt;
          s_drive = s_alt;
        end
        for (int r = 0; r < 3; r++) begin
          case (mode)
            0:       d[r] = 16'(h);
            1:       d[r] = val;
            2:       d[r] = (h == 0) ? 16'hF800 : 16'h0000;
            default: d[r] = 16'($urandom);
          endcase
        end
        drive_px(h, v, d[0], d[1], d[2]);
        if (int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(3, 1)));
      end
    end
  endtask

  task automatic set_kernel(input int c0, c1, c2, c3, c4, c5, c6, c7, c8, input int s);
    int t [9];
    t = '{c0, c1, c2, c3, c4, c5, c6, c7, c8};
    for (int i = 0; i < 9; i++) k_drive[i] = 8'(t[i]);
    s_drive = 4'(s);
  endtask

  task automatic rand_kernel(input bit wide);
    for (int i = 0; i < 9; i++)
      k_drive[i] = wide ? 8'($urandom) : 8'(int'($urandom_range(16)) - 8);
    s_drive = wide ? 4'($urandom) : 4'($urandom_range(3));
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    total++;
    if ({bus.line_out, bus.hcount_out, bus.vcount_out, bus.data_valid_out} !== 22'd0)
      $display("FAIL reset_outputs: got line=%h h=%0d v=%0d vld=%b, want all 0",
               bus.line_out, bus.hcount_out, bus.vcount_out, bus.data_valid_out);
    else passed++;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    repeat (6) @(posedge clk_in);
    @(negedge clk_in);
    total++;
    if (bus.data_valid_out !== 1'b0)
      $display("FAIL reset_idle_valid: got %b, want 0", bus.data_valid_out);
    else passed++;
  endtask

  task automatic test_identity();
    set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    drive_frame(0, 16'h0, 20, -1);
    drive_frame(0, 16'h0, 0, -1);
    idle(8);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        $display("FAIL identity: no output, want pix=%h h=%0d v=%0d cyc=%0d", e.pix, e.h, e.v, e.cyc);
        continue;
      end
      g = got_q.pop_front();
      if (g !== e)
        $display("FAIL identity: got pix=%h h=%0d v=%0d cyc=%0d, want pix=%h h=%0d v=%0d cyc=%0d",
                 g.pix, g.h, g.v, g.cyc, e.pix, e.h, e.v, e.cyc);
      else passed++;
      if (e.h == 3'd7 && e.v == 2'd0 && e.cyc > 32'd20) begin
        total++;
        if (g.pix !== 16'h0007 || g.h !== 3'd7 || g.v !== 2'd0)
          $display("FAIL identity_row_wrap: got pix=%h h=%0d v=%0d, want pix=0007 h=7 v=0",
                   g.pix, g.h, g.v);
        else passed++;
      end
    end
    total++;
    if (got_q.size() != 0) $display("FAIL identity_extra: got %0d outputs, want 0", got_q.size());
    else passed++;
    got_q.delete();
  endtask

  task automatic test_kernels();
    set_kernel(1, 2, 1, 2, 4, 2, 1, 2, 1, 4);
    drive_frame(1, 16'h8410, 10, -1);
    set_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
    drive_frame(1, 16'hFFFF, 10, -1);
    set_kernel(0, -1, 0, -1, 4, -1, 0, -1, 0, 0);
    drive_frame(1, 16'hFFFF, 10, -1);
    idle(8);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        $display("FAIL kernels: no output, want pix=%h h=%0d v=%0d cyc=%0d", e.pix, e.h, e.v, e.cyc);
        continue;
      end
      g = got_q.pop_front();
      if (g !== e)
        $display("FAIL kernels: got pix=%h h=%0d v=%0d cyc=%0d, want pix=%h h=%0d v=%0d cyc=%0d",
                 g.pix, g.h, g.v, g.cyc, e.pix, e.h, e.v, e.cyc);
      else passed++;
    end
    total++;
    if (got_q.size() != 0) $display("FAIL kernels_extra: got %0d outputs, want 0", got_q.size());
    else passed++;
    got_q.delete();
  endtask

  task automatic test_edge_clamp();
    logic [15:0] want_edge;
`ifdef CONV_EDGE_CLAMP_EN
    want_edge = 16'hB800;
`else
    want_edge = 16'h5800;
`endif
    set_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1, 3);
    drive_frame(2, 16'h0, 15, -1);
    idle(8);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        $display("FAIL edge_clamp: no output, want pix=%h h=%0d v=%0d cyc=%0d", e.pix, e.h, e.v, e.cyc);
        continue;
      end
      g = got_q.pop_front();
      if (g !== e)
        $display("FAIL edge_clamp: got pix=%h h=%0d v=%0d cyc=%0d, want pix=%h h=%0d v=%0d cyc=%0d",
                 g.pix, g.h, g.v, g.cyc, e.pix, e.h, e.v, e.cyc);
      else passed++;
      if (e.h == 3'd0 && e.v == 2'd1) begin
        total++;
        if (g.pix !== want_edge)
          $display("FAIL edge_clamp_col0: got %h, want %h", g.pix, want_edge);
        else passed++;
      end
    end
    total++;
    if (got_q.size() != 0) $display("FAIL edge_clamp_extra: got %0d outputs, want 0", got_q.size());
    else passed++;
    got_q.delete();
  endtask

  task automatic test_coeff_change();
    rand_kernel(1'b0);
    k_alt = k_drive;
    s_alt = s_drive;
    rand_kernel(1'b0);
    drive_frame(3, 16'h0, 10, 11);
    drive_frame(3, 16'h0, 10, -1);
    idle(8);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        $display("FAIL coeff_change: no output, want pix=%h h=%0d v=%0d cyc=%0d", e.pix, e.h, e.v, e.cyc);
        continue;
      end
      g = got_q.pop_front();
      if (g !== e)
        $display("FAIL coeff_change: got pix=%h h=%0d v=%0d cyc=%0d, want pix=%h h=%0d v=%0d cyc=%0d",
                 g.pix, g.h, g.v, g.cyc, e.pix, e.h, e.v, e.cyc);
      else passed++;
    end
    total++;
    if (got_q.size() != 0) $display("FAIL coeff_change_extra: got %0d outputs, want 0", got_q.size());
    else passed++;
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    rand_kernel(1'b1);
    drive_frame(3, 16'h0, 0, -1);
    rand_kernel(1'b0);
    drive_frame(3, 16'h0, 0, -1);
    idle(8);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        $display("FAIL back_to_back: no output, want pix=%h h=%0d v=%0d cyc=%0d", e.pix, e.h, e.v, e.cyc);
        continue;
      end
      g = got_q.pop_front();
      if (g !== e)
        $display("FAIL back_to_back: got pix=%h h=%0d v=%0d cyc=%0d, want pix=%h h=%0d v=%0d cyc=%0d",
                 g.pix, g.h, g.v, g.cyc, e.pix, e.h, e.v, e.cyc);
      else passed++;
    end
    total++;
    if (got_q.size() != 0) $display("FAIL back_to_back_extra: got %0d outputs, want 0", got_q.size());
    else passed++;
    got_q.delete();
  endtask

  task automatic test_mid_reset();
    logic [31:0] k, m;
    out_t keep[$];
    int early;
    rand_kernel(1'b0);
    for (int h = 0; h < 6; h++) drive_px(h, 0, 16'($urandom), 16'($urandom), 16'($urandom));
    @(posedge clk_in); #1;
    bus.data_valid_in = 1'b0;
    rst_in = 1'b1;
    k = cyc;
    model_reset();
    foreach (exp_q[i]) if (exp_q[i].cyc <= k) keep.push_back(exp_q[i]);
    exp_q = keep;
    idle(2);
    set_kernel(1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
    drive_px(2, 1, 16'($urandom), 16'($urandom), 16'($urandom));
    m = last_cyc;
    for (int h = 3; h < 8; h++) drive_px(h, 1, 16'($urandom), 16'($urandom), 16'($urandom));
    idle(8);
    early = 0;
    foreach (got_q[i]) if (got_q[i].cyc > k && got_q[i].cyc <= m + 4) early++;
    total++;
    if (early != 0) $display("FAIL mid_reset_quiet: got %0d valid outputs, want 0", early);
    else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        $display("FAIL mid_reset: no output, want pix=%h h=%0d v=%0d cyc=%0d", e.pix, e.h, e.v, e.cyc);
        continue;
      end
      g = got_q.pop_front();
      if (g !== e)
        $display("FAIL mid_reset: got pix=%h h=%0d v=%0d cyc=%0d, want pix=%h h=%0d v=%0d cyc=%0d",
                 g.pix, g.h, g.v, g.cyc, e.pix, e.h, e.v, e.cyc);
      else passed++;
    end
    total++;
    if (got_q.size() != 0) $display("FAIL mid_reset_extra: got %0d outputs, want 0", got_q.size());
    else passed++;
    got_q.delete();
  endtask

  initial begin
    bus.data_valid_in = 1'b0;
    bus.hcount_in     = '0;
    bus.vcount_in     = '0;
    bus.shift_in      = '0;
    for (int r = 0; r < 3; r++) bus.data_in[r] = '0;
    for (int i = 0; i < 9; i++) bus.coeffs_in[i] = '0;
    set_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_identity();
    test_kernels();
    test_edge_clamp();
    test_coeff_change();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
